adc_capture_trigger: RTL and testbench
======================================

// Module: adc_capture_trigger
// PURPOSE
//  Gates one RF-ADC AXIS stream into a capture window of cap_beats beats, started by an arm command plus a trigger.
//  Sits directly upstream of the per-stream FIFOs of the ADC-to-DDR data path, in the rf_clk domain.
//  Trigger source: immediate, signed level crossing within the sample stream, or an external strobe.
//  Adds tlast on the final beat and reports overflow when downstream back-pressure costs samples.
// PARAMETERS
//  DATA_W    128  stream width; carries DATA_W/SAMPLE_W samples, sample 0 in the LSBs (oldest)
//  SAMPLE_W  16   signed sample width
//  CNT_W     32   width of cap_beats and beat_count
// PORTS
//  rf_clk         in   1         ADC stream clock; all logic is synchronous to it
//  rf_rstb        in   1         asynchronous, active-low reset
//  s_axis_tvalid  in   1         ADC beat valid
//  s_axis_tready  out  1         tied 1: the ADC cannot be stalled
//  s_axis_tdata   in   DATA_W    ADC samples
//  m_axis_tvalid  out  1         captured beat valid
//  m_axis_tready  in   1         downstream FIFO ready
//  m_axis_tdata   out  DATA_W    captured samples
//  m_axis_tlast   out  1         final beat of the window
//  arm            in   1         1-cycle pulse: start a capture
//  abort          in   1         1-cycle pulse: cancel the capture; abort has priority over arm
//  trig_mode      in   2         0 = immediate, 1 = rising level crossing, 2 = ext_trig, 3 = reserved (never triggers)
//  trig_level     in   SAMPLE_W  signed threshold for mode 1
//  ext_trig       in   1         external trigger level, already in the rf_clk domain
//  cap_beats      in   CNT_W     window length in beats; sampled on arm
//  state          out  2         0 = IDLE, 1 = ARMED, 2 = CAPTURE, 3 = DONE
//  beat_count     out  CNT_W     window beats consumed so far, including dropped beats
//  overflow       out  1         sticky: at least one window beat was dropped; cleared on arm
//  cap_done       out  1         level: the window is complete; cleared on arm or abort
// BEHAVIOUR
//  Reset: state=IDLE; m_axis_tvalid, m_axis_tlast, overflow, cap_done = 0; beat_count = 0; data register = 0; prev sample = 0 and flagged invalid.
//  FSM:
//   IDLE  -> ARMED   on arm with cap_beats != 0. Arm with cap_beats == 0 is ignored.
//   ARMED -> CAPTURE on a triggering valid beat. That beat is window beat 1.
//   CAPTURE -> DONE  when beat number cap_beats is consumed.
//   DONE  -> ARMED   on arm.
//  Arm while ARMED re-latches cap_beats. Arm while in CAPTURE is ignored.
//  Abort in any state -> IDLE, and clears m_axis_tvalid on the next edge, discarding any held beat.
//  Trigger, evaluated only on valid beats in ARMED:
//   mode 0: the first valid beat.
//   mode 2: a valid beat with ext_trig = 1 in the same cycle.
//   mode 1: any i with sample[i] >= trig_level and sample[i-1] < trig_level (signed compares).
//    For sample[0], sample[-1] is the last sample of the previous valid beat.
//    The previous-beat sample is invalid on the first beat after entering ARMED, so sample 0 of that beat cannot trigger.
//  Output register, single-entry; latency 1 cycle from s_axis to m_axis:
//   A window beat loads when (!m_axis_tvalid || m_axis_tready). Otherwise the beat is dropped and overflow is set.
//   beat_count increments on every window beat, loaded or dropped, so the window is a fixed time span.
//   m_axis_tlast = 1 with the beat whose number equals cap_beats.
//   m_axis_tvalid falls after its handshake unless a new beat loads in the same cycle.
//  cap_done rises in the cycle after the tlast beat is handshaked.
//   If the tlast beat itself is dropped, cap_done rises on entry to DONE.
//  beat_count reset: cleared on arm; holds its value in DONE and IDLE.
//  Data-path invariants:
//   tdata passes through unmodified.
//   No combinational path from s_axis to m_axis.
//   s_axis_tready is constant 1.
// TESTING
//  T1 mode 0, cap_beats=4, continuous valid, tready=1:
//     -> 4 beats out, each 1 cycle late; tlast on beat 4; cap_done=1; state=DONE; overflow=0.
//  T2 mode 1, level=100; beat A samples all 50; beat B = {50,50,120,...}:
//     -> B is the first output beat.
//     Then a beat with sample0=120 after a previous last sample of 50 also triggers.
//  T3 mode 1, the first beat after arm has sample0=200 and the prior beat ended at 0:
//     -> no trigger (previous sample invalid), state stays ARMED.
//  T4 cap_beats=8, tready held low for 3 cycles mid-window:
//     -> 2 beats dropped; overflow=1; beat_count=8; 6 beats out; tlast still on window beat 8.
//  T5 abort during CAPTURE with m_axis_tvalid=1 and tready=0:
//     -> next cycle m_axis_tvalid=0, state=IDLE, cap_done=0.
//     A following arm restarts cleanly with overflow=0.
//  T6 arm with cap_beats=0 -> stays IDLE.
//     Arm in CAPTURE -> ignored, beat_count continues.
//     Arm and abort in the same cycle -> IDLE.

Source files
------------

// File: rtl/adc_capture_trigger.sv
// adc_capture_trigger: gates one RF-ADC AXIS stream into a fixed-length
// capture window. An arm command plus a trigger open the window, and the
// final beat of the window carries tlast. Beats that find the single-entry
// output register still occupied are dropped, and the sticky overflow flag
// records the loss. The window length always stays a fixed time span.
module adc_capture_trigger #(
    parameter int DATA_W   = 128,
    parameter int SAMPLE_W = 16,
    parameter int CNT_W    = 32
) (
    input  logic                       rf_clk,
    input  logic                       rf_rstb,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [DATA_W-1:0]          s_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic                       m_axis_tlast,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [1:0]                 trig_mode,
    input  logic signed [SAMPLE_W-1:0] trig_level,
    input  logic                       ext_trig,
    input  logic [CNT_W-1:0]           cap_beats,
    output logic [1:0]                 state,
    output logic [CNT_W-1:0]           beat_count,
    output logic                       overflow,
    output logic                       cap_done
);

    localparam int NUM_S = DATA_W / SAMPLE_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                     cur_state;
    logic [CNT_W-1:0]           cap_len;
    logic signed [SAMPLE_W-1:0] prev_sample;
    logic                       prev_valid;

    logic                       arm_ok;
    logic                       level_hit;
    logic                       trigger;
    logic                       window_beat;
    logic                       is_last;
    logic                       load;
    logic signed [SAMPLE_W-1:0] cur_s;
    logic signed [SAMPLE_W-1:0] prv_s;
    logic                       prv_ok;

    // The ADC cannot be stalled.
    assign s_axis_tready = 1'b1;
    assign state         = cur_state;

    // An arm is accepted only when abort is absent, the length is non-zero,
    // and no window is in progress.
    assign arm_ok = arm && !abort && (cap_beats != '0) && (cur_state != CAPTURE);

    // Rising level crossing anywhere in the beat. Sample 0 is compared
    // against the last sample of the previous valid beat.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        level_hit = 1'b0;
        cur_s     = '0;
        prv_s     = '0;
        prv_ok    = 1'b0;
        for (int i = 0; i < NUM_S; i++) begin
            cur_s = s_axis_tdata[i*SAMPLE_W +: SAMPLE_W];
            if (i == 0) begin
                prv_s  = prev_sample;
                prv_ok = prev_valid;
            end else begin
                prv_s  = s_axis_tdata[(i-1)*SAMPLE_W +: SAMPLE_W];
                prv_ok = 1'b1;
            end
            if (prv_ok && (cur_s >= trig_level) && (prv_s < trig_level)) begin
                level_hit = 1'b1;
            end
        end
    end

    // Trigger source selection. Mode 3 never fires.
    always_comb begin
        trigger = 1'b0;
        case (trig_mode)
            2'd0:    trigger = 1'b1;
            2'd1:    trigger = level_hit;
            2'd2:    trigger = ext_trig;
            default: trigger = 1'b0;
        endcase
    end

    // A window beat is the triggering beat in ARMED, or any valid beat in CAPTURE.
    assign window_beat = s_axis_tvalid && !abort &&
                         (((cur_state == ARMED) && !arm_ok && trigger) ||
                          (cur_state == CAPTURE));
    assign is_last     = ((beat_count + CNT_W'(1)) == cap_len);
    assign load        = window_beat && (!m_axis_tvalid || m_axis_tready);

    // Control FSM, window bookkeeping and status flags.
    always_ff @(posedge rf_clk or negedge rf_rstb) begin
        if (!rf_rstb) begin
            cur_state   <= IDLE;
            cap_len     <= '0;
            beat_count  <= '0;
            overflow    <= 1'b0;
            cap_done    <= 1'b0;
            prev_sample <= '0;
            prev_valid  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register see pre-edge values, whatever the statement order.
            if (abort) begin
                cur_state <= IDLE;
            end else begin
                case (cur_state)
                    IDLE:    if (arm_ok) cur_state <= ARMED;
                    ARMED:   if (!arm_ok && window_beat) cur_state <= is_last ? DONE : CAPTURE;
                    CAPTURE: if (window_beat && is_last) cur_state <= DONE;
                    DONE:    if (arm_ok) cur_state <= ARMED;
                    default: cur_state <= IDLE;
                endcase
            end

            if (arm_ok) begin
                cap_len    <= cap_beats;
                beat_count <= '0;
            end else if (window_beat) begin
                beat_count <= beat_count + CNT_W'(1);
            end

            if (arm_ok) begin
                overflow <= 1'b0;
            end else if (window_beat && !load) begin
                overflow <= 1'b1;
            end

            if (abort || arm_ok) begin
                cap_done <= 1'b0;
            end else if ((cur_state == DONE) && m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                cap_done <= 1'b1;
            end else if (window_beat && is_last && !load) begin
                cap_done <= 1'b1;
            end

            // The first beat after arming has no valid predecessor sample.
            if (arm_ok) begin
                prev_valid <= 1'b0;
            end else if (s_axis_tvalid) begin
                prev_sample <= s_axis_tdata[DATA_W-1 -: SAMPLE_W];
                prev_valid  <= 1'b1;
            end
        end
    end

    // Single-entry output register: one cycle of latency, with no combinational path from s_axis.
    always_ff @(posedge rf_clk or negedge rf_rstb) begin
        if (!rf_rstb) begin
            // NOTE: the data register is a plain flop rather than a memory, so it is cheap to reset to a known value.
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (abort) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= is_last;
            m_axis_tdata  <= s_axis_tdata;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_capture_trigger.sv
// Directed bench for adc_capture_trigger. Expected values are hand-derived
// per step. Handshaked output beats are collected for end-of-window checks.
module tb_adc_capture_trigger;

    localparam int DW = 128;

    logic          rf_clk = 1'b0;
    logic          rf_rstb;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;
    logic          arm, abort, ext_trig;
    logic [1:0]    trig_mode, state;
    logic [15:0]   trig_level;
    logic [31:0]   cap_beats, beat_count;
    logic          overflow, cap_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] hs_q[$];
    logic          hs_last[$];

    adc_capture_trigger #(.DATA_W(128), .SAMPLE_W(16), .CNT_W(32)) dut (
        .rf_clk(rf_clk), .rf_rstb(rf_rstb),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
        .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
        .m_axis_tlast(m_last),
        .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_level(trig_level),
        .ext_trig(ext_trig), .cap_beats(cap_beats),
        .state(state), .beat_count(beat_count), .overflow(overflow), .cap_done(cap_done)
    );

    always #5 rf_clk = ~rf_clk;

    // Record every output handshake.
    always @(posedge rf_clk) begin
        if (rf_rstb && m_valid && m_ready) begin
            hs_q.push_back(m_data);
            hs_last.push_back(m_last);
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge. Outputs are sampled 1 ns later, and the pulse inputs are released.
    task automatic tick();
        @(posedge rf_clk);
        #1;
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
        s_valid = v;
        s_data  = d;
        m_ready = r;
        tick();
    endtask

    task automatic do_arm(input logic [1:0] mode, input logic [31:0] len);
        trig_mode = mode;
        cap_beats = len;
        arm       = 1'b1;
        s_valid   = 1'b0;
        tick();
    endtask

    // Beat with sample0 = s0, sample1 = s1, samples 2..7 = rest.
    function automatic logic [DW-1:0] mk(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] rest);
        return {{6{rest}}, s1, s0};
    endfunction

    function automatic logic [DW-1:0] bt(input int k);
        return mk(16'(k), 16'(k + 16'h100), 16'(16'hA000 + k));
    endfunction

    initial begin
        rf_rstb = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        arm = 1'b0; abort = 1'b0; trig_mode = 2'd0; trig_level = 16'd0;
        ext_trig = 1'b0; cap_beats = 32'd0;
        repeat (3) @(posedge rf_clk);
        #2 rf_rstb = 1'b1;
        #1;

        // Reset state
        check("rst_state", state, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_tlast", m_last, 0);
        check("rst_ovf", overflow, 0);
        check("rst_done", cap_done, 0);
        check("rst_bcnt", beat_count, 0);
        check("rst_tdata", m_data, 0);
        check("s_tready", s_ready, 1);

        // T1: immediate trigger, 4 beats
        do_arm(2'd0, 32'd4);
        check("t1_armed", state, 1);
        hs_q.delete(); hs_last.delete();
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, bt(k), 1'b1);
            check("t1_data", m_data, bt(k));
            check("t1_bcnt", beat_count, 32'(k));
            check("t1_last", m_last, (k == 4));
            check("t1_done_early", cap_done, 0);
        end
        check("t1_state_done", state, 3);
        cyc(1'b0, '0, 1'b1);
        check("t1_cap_done", cap_done, 1);
        check("t1_mvalid_fall", m_valid, 0);
        check("t1_ovf", overflow, 0);
        check("t1_nbeats", hs_q.size(), 4);
        if (hs_last.size() == 4) check("t1_hs_last", hs_last[3], 1);

        // T2: rising level crossing at 100
        trig_level = 16'd100;
        do_arm(2'd1, 32'd2);
        cyc(1'b1, mk(50, 50, 50), 1'b1);
        check("t2_a_no_trig", state, 1);
        check("t2_a_no_out", m_valid, 0);
        cyc(1'b1, mk(50, 50, 120), 1'b1);
        check("t2_b_trig", state, 2);
        check("t2_b_data", m_data, mk(50, 50, 120));
        check("t2_b_bcnt", beat_count, 1);
        cyc(1'b1, mk(7, 8, 9), 1'b1);
        check("t2_done", state, 3);
        check("t2_last", m_last, 1);
        cyc(1'b0, '0, 1'b1);
        check("t2_cap_done", cap_done, 1);
        do_arm(2'd1, 32'd1);
        check("t2_rearm_clr", cap_done, 0);
        cyc(1'b1, mk(50, 50, 50), 1'b1);
        check("t2_e_no_trig", state, 1);
        cyc(1'b1, mk(120, 80, 80), 1'b1);
        check("t2_s0_trig", state, 3);
        check("t2_s0_data", m_data, mk(120, 80, 80));
        check("t2_s0_last", m_last, 1);
        cyc(1'b0, '0, 1'b1);

        // T3: previous sample invalid on first beat after arm
        cyc(1'b1, mk(0, 0, 0), 1'b1);
        do_arm(2'd1, 32'd1);
        cyc(1'b1, mk(200, 200, 200), 1'b1);
        check("t3_no_trig", state, 1);
        check("t3_no_out", m_valid, 0);
        abort = 1'b1;
        cyc(1'b0, '0, 1'b1);
        check("t3_abort_idle", state, 0);

        // T4: back-pressure, 2 beats dropped in an 8-beat window
        do_arm(2'd0, 32'd8);
        hs_q.delete(); hs_last.delete();
        cyc(1'b1, bt(1), 1'b1);
        cyc(1'b1, bt(2), 1'b1);
        cyc(1'b0, '0,    1'b0);
        cyc(1'b1, bt(3), 1'b0);
        cyc(1'b1, bt(4), 1'b0);
        check("t4_ovf", overflow, 1);
        check("t4_hold", m_data, bt(2));
        for (int k = 5; k <= 8; k++) cyc(1'b1, bt(k), 1'b1);
        check("t4_state", state, 3);
        check("t4_bcnt", beat_count, 8);
        check("t4_last", m_last, 1);
        check("t4_last_data", m_data, bt(8));
        cyc(1'b0, '0, 1'b1);
        check("t4_cap_done", cap_done, 1);
        check("t4_nbeats", hs_q.size(), 6);
        if (hs_q.size() == 6) begin
            check("t4_b3", hs_q[2], bt(5));
            check("t4_b6", hs_q[5], bt(8));
            check("t4_l5", hs_last[4], 0);
            check("t4_l6", hs_last[5], 1);
        end

        // T5: abort with a held beat
        do_arm(2'd0, 32'd8);
        check("t5_ovf_clr", overflow, 0);
        cyc(1'b1, bt(1), 1'b0);
        cyc(1'b1, bt(2), 1'b0);
        check("t5_held", m_valid, 1);
        check("t5_cap", state, 2);
        abort = 1'b1;
        cyc(1'b1, bt(3), 1'b0);
        check("t5_mvalid", m_valid, 0);
        check("t5_idle", state, 0);
        check("t5_done", cap_done, 0);
        do_arm(2'd0, 32'd2);
        check("t5_rearm", state, 1);
        check("t5_rearm_ovf", overflow, 0);
        check("t5_rearm_bcnt", beat_count, 0);
        cyc(1'b1, bt(1), 1'b1);
        cyc(1'b1, bt(2), 1'b1);
        cyc(1'b0, '0, 1'b1);
        check("t5_cap_done", cap_done, 1);
        check("t5_ovf_end", overflow, 0);

        // T6: arm corner cases
        abort = 1'b1;
        cyc(1'b0, '0, 1'b1);
        do_arm(2'd0, 32'd0);
        check("t6_zero_len", state, 0);
        do_arm(2'd0, 32'd5);
        do_arm(2'd0, 32'd1);
        cyc(1'b1, bt(9), 1'b1);
        check("t6_relatch", state, 3);
        check("t6_relatch_last", m_last, 1);
        cyc(1'b0, '0, 1'b1);
        do_arm(2'd0, 32'd5);
        cyc(1'b1, bt(1), 1'b1);
        cap_beats = 32'd2;
        arm = 1'b1;
        cyc(1'b1, bt(2), 1'b1);
        check("t6_arm_in_cap", state, 2);
        check("t6_bcnt2", beat_count, 2);
        cyc(1'b1, bt(3), 1'b1);
        check("t6_bcnt3", beat_count, 3);
        check("t6_no_last", m_last, 0);
        arm = 1'b1; abort = 1'b1;
        cyc(1'b1, bt(4), 1'b1);
        check("t6_arm_abort", state, 0);
        check("t6_hold_bcnt", beat_count, 3);

        // External trigger and reserved mode
        do_arm(2'd2, 32'd1);
        ext_trig = 1'b0;
        cyc(1'b1, bt(5), 1'b1);
        check("ext_wait", state, 1);
        ext_trig = 1'b1;
        cyc(1'b1, bt(6), 1'b1);
        check("ext_fire", state, 3);
        check("ext_data", m_data, bt(6));
        cyc(1'b0, '0, 1'b1);
        do_arm(2'd3, 32'd1);
        cyc(1'b1, bt(7), 1'b1);
        check("mode3_never", state, 1);
        ext_trig = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
